f4_sweep_checker: RTL and testbench



---
 rtl/f4_sweep_checker.sv | 173 +++++++++++++++++
 tb/tb_f4_sweep_checker.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/f4_sweep_checker.sv
// Drives all 16 vectors of f(x1..x4) into two implementations, samples them after a
// programmable settle time and checks them against a golden truth table.
module f4_sweep_checker #(
    parameter int          SETTLE = 2,
    parameter logic [15:0] GOLDEN = 16'hD0E3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic        dut_a_out,
    input  logic        dut_b_out,
    output logic        x1,
    output logic        x2,
    output logic        x3,
    output logic        x4,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] tt_a,
    output logic [15:0] tt_b,
    output logic [4:0]  err_a,
    output logic [4:0]  err_b,
    output logic        fail_valid,
    output logic [3:0]  fail_idx
);

    // state    | meaning
    // S_IDLE   | reset / aborted, waiting for start
    // S_RUN    | sweeping vectors, sampling after SETTLE wait cycles
    // S_DONE   | sweep complete, results held until next start
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE_C = 4'(SETTLE);

    state_t      state_q, state_d;
    logic [3:0]  vec_q, vec_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  x_q, x_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        pass_q, pass_d;
    logic [15:0] tt_a_q, tt_a_d;
    logic [15:0] tt_b_q, tt_b_d;
    logic [4:0]  err_a_q, err_a_d;
    logic [4:0]  err_b_q, err_b_d;
    logic        fail_valid_q, fail_valid_d;
    logic [3:0]  fail_idx_q, fail_idx_d;
    logic        mis_a, mis_b;

    assign mis_a = dut_a_out != GOLDEN[vec_q];
    assign mis_b = dut_b_out != GOLDEN[vec_q];

    always_comb begin
        state_d      = state_q;
        vec_d        = vec_q;
        cnt_d        = cnt_q;
        busy_d       = busy_q;
        done_d       = done_q;
        pass_d       = pass_q;
        tt_a_d       = tt_a_q;
        tt_b_d       = tt_b_q;
        err_a_d      = err_a_q;
        err_b_d      = err_b_q;
        fail_valid_d = fail_valid_q;
        fail_idx_d   = fail_idx_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d      = S_RUN;
                    vec_d        = 4'd0;
                    cnt_d        = 4'd0;
                    busy_d       = 1'b1;
                    done_d       = 1'b0;
                    pass_d       = 1'b0;
                    tt_a_d       = 16'd0;
                    tt_b_d       = 16'd0;
                    err_a_d      = 5'd0;
                    err_b_d      = 5'd0;
                    fail_valid_d = 1'b0;
                    fail_idx_d   = 4'd0;
                end
            end
            S_RUN: begin
                if (abort) begin
                    // partial results are kept for post-mortem inspection
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b0;
                    vec_d   = 4'd0;
                    cnt_d   = 4'd0;
                end else if (cnt_q != SETTLE_C) begin
                    cnt_d = cnt_q + 4'd1;
                end else begin
                    tt_a_d[vec_q] = dut_a_out;
                    tt_b_d[vec_q] = dut_b_out;
                    err_a_d       = err_a_q + 5'(mis_a);
                    err_b_d       = err_b_q + 5'(mis_b);
                    if (!fail_valid_q && (mis_a || mis_b)) begin
                        fail_valid_d = 1'b1;
                        fail_idx_d   = vec_q;
                    end
                    cnt_d = 4'd0;
                    if (vec_q == 4'd15) begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (err_a_d == 5'd0) && (err_b_d == 5'd0);
                    end else begin
                        vec_d = vec_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        x_d = (state_d == S_RUN) ? vec_d : 4'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            vec_q        <= 4'd0;
            cnt_q        <= 4'd0;
            x_q          <= 4'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            tt_a_q       <= 16'd0;
            tt_b_q       <= 16'd0;
            err_a_q      <= 5'd0;
            err_b_q      <= 5'd0;
            fail_valid_q <= 1'b0;
            fail_idx_q   <= 4'd0;
        end else begin
            state_q      <= state_d;
            vec_q        <= vec_d;
            cnt_q        <= cnt_d;
            x_q          <= x_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            tt_a_q       <= tt_a_d;
            tt_b_q       <= tt_b_d;
            err_a_q      <= err_a_d;
            err_b_q      <= err_b_d;
            fail_valid_q <= fail_valid_d;
            fail_idx_q   <= fail_idx_d;
        end
    end

    assign x1         = x_q[3];
    assign x2         = x_q[2];
    assign x3         = x_q[1];
    assign x4         = x_q[0];
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign tt_a       = tt_a_q;
    assign tt_b       = tt_b_q;
    assign err_a      = err_a_q;
    assign err_b      = err_b_q;
    assign fail_valid = fail_valid_q;
    assign fail_idx   = fail_idx_q;

endmodule

// File: tb/tb_f4_sweep_checker.sv
// Bench for f4_sweep_checker: implementations are modelled as the boolean function with
// per-vector fault masks; expected results are derived from those masks.
module tb_f4_sweep_checker;

    localparam int SETTLE = 2;
    localparam int HOLD   = SETTLE + 1;
    localparam int BUSY_N = 16 * HOLD;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        dut_a_out, dut_b_out;
    logic        x1, x2, x3, x4;
    logic        busy, done, pass;
    logic [15:0] tt_a, tt_b;
    logic [4:0]  err_a, err_b;
    logic        fail_valid;
    logic [3:0]  fail_idx;

    logic [15:0] flip_a = 16'd0;
    logic [15:0] flip_b = 16'd0;
    logic [3:0]  xv;

    int checks = 0;
    int failures = 0;

    f4_sweep_checker #(.SETTLE(SETTLE), .GOLDEN(16'hD0E3)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .dut_a_out(dut_a_out), .dut_b_out(dut_b_out),
        .x1(x1), .x2(x2), .x3(x3), .x4(x4),
        .busy(busy), .done(done), .pass(pass),
        .tt_a(tt_a), .tt_b(tt_b), .err_a(err_a), .err_b(err_b),
        .fail_valid(fail_valid), .fail_idx(fail_idx)
    );

    always #5 clk = ~clk;

    function automatic logic f_ref(input logic [3:0] v);
        logic a, b, c, d;
        {a, b, c, d} = v;
        return (!a && !b && !c) || (!a && !c && d) || (a && b && !d) || (b && c);
    endfunction

    function automatic logic [15:0] table_ref();
        logic [15:0] t;
        for (int i = 0; i < 16; i++) t[i] = f_ref(4'(i));
        return t;
    endfunction

    assign xv        = {x1, x2, x3, x4};
    assign dut_a_out = f_ref(xv) ^ flip_a[xv];
    assign dut_b_out = f_ref(xv) ^ flip_b[xv];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return {x1, x2, x3, x4, busy, done, pass, tt_a, tt_b, err_a, err_b, fail_valid, fail_idx};
    endfunction

    // Full sweep with current fault masks; optionally pulses start mid-sweep.
    task automatic run_sweep(input string tag, input bit mid_start);
        int n = 0;
        int bad_hold = 0;
        int hold[16];
        logic [15:0] any;
        int first = 0;
        for (int i = 0; i < 16; i++) hold[i] = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk({tag, ".started"}, {busy, done}, 2'b10);
        while (busy && n < 4 * BUSY_N) begin
            hold[xv]++;
            n++;
            start = (mid_start && n == 10);
            @(negedge clk);
        end
        start = 1'b0;
        for (int i = 0; i < 16; i++) if (hold[i] != HOLD) bad_hold++;
        any = flip_a | flip_b;
        for (int i = 15; i >= 0; i--) if (any[i]) first = i;
        chk({tag, ".busy_len"}, n, BUSY_N);
        chk({tag, ".hold"}, bad_hold, 0);
        chk({tag, ".done"}, {done, xv}, {1'b1, 4'd0});
        chk({tag, ".tt_a"}, tt_a, table_ref() ^ flip_a);
        chk({tag, ".tt_b"}, tt_b, table_ref() ^ flip_b);
        chk({tag, ".err"}, {err_a, err_b}, {5'($countones(flip_a)), 5'($countones(flip_b))});
        chk({tag, ".pass"}, pass, any == 16'd0);
        chk({tag, ".fail"}, {fail_valid, fail_idx}, {any != 16'd0, 4'(first)});
    endtask

    initial begin
        int n;
        #23;
        chk("reset_state", all_outs(), 64'd0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        chk("idle_after_reset", all_outs(), 64'd0);

        chk("golden_table", table_ref(), 16'hD0E3);

        flip_a = 16'd0; flip_b = 16'd0;
        run_sweep("ideal", 1'b0);

        flip_a = 16'd0; flip_b = table_ref();
        run_sweep("b_stuck0", 1'b0);

        flip_a = 16'h1000; flip_b = 16'd0;
        run_sweep("a_inv12", 1'b0);

        flip_a = 16'd0; flip_b = 16'd0;
        run_sweep("mid_start", 1'b1);

        for (int r = 0; r < 6; r++) begin
            flip_a = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom & $urandom);
            flip_b = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom & $urandom);
            run_sweep($sformatf("rand%0d", r), 1'b0);
        end

        // abort on the sample edge of vector 5
        flip_a = 16'd0; flip_b = 16'd0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        n = 0;
        while (n < 5 * HOLD + SETTLE) begin
            n++;
            @(negedge clk);
        end
        chk("abort.vec5", {busy, xv}, {1'b1, 4'd5});
        abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        chk("abort.ctl", {busy, done, xv}, 6'd0);
        chk("abort.tt_a", tt_a, table_ref() & 16'h001F);
        @(negedge clk);
        chk("abort.idle", {busy, done}, 2'b00);
        run_sweep("after_abort", 1'b0);

        // reset at vector 7
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        n = 0;
        while (n < 7 * HOLD + 1) begin
            n++;
            @(negedge clk);
        end
        chk("rst.vec7", {busy, xv}, {1'b1, 4'd7});
        rst_n = 1'b0;
        #1;
        chk("rst.mid_sweep", all_outs(), 64'd0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        chk("rst.idle", all_outs(), 64'd0);
        run_sweep("after_reset", 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
